frame_capture_ctrl: RTL and testbench
=====================================

# frame_capture_ctrl

Sequences camera frame capture into a double-buffered frame store. Sits downstream of the pixel assembler in the `p_clock` domain. It consumes the 16-bit pixel stream, the frame-done pulse and raw `vsync`, and arms capture on a clean frame boundary. It generates frame-buffer write address/enable, swaps buffer banks only on complete frames, and reports status and errors to the system controller.

## Interface
Parameters:
- `H_RES`, 320, active pixels per line
- `V_RES`, 240, active lines per frame
- `ADDR_W`, 17, write address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES

Ports:
- `p_clock`  in  1  pixel clock; sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `vsync`  in  1  raw camera vsync; high = vertical blanking
- `pixel_data`  in  16  assembled RGB565 pixel
- `pixel_valid`  in  1  one-cycle qualifier for `pixel_data`
- `frame_done`  in  1  one-cycle end-of-frame pulse
- `cmd_start`  in  1  one-cycle pulse: arm capture, clear errors
- `cmd_stop`  in  1  one-cycle pulse: stop after current frame
- `cmd_continuous`  in  1  level, sampled at `cmd_start`: 1 = run until stopped, 0 = single frame
- `wr_en`  out  1  frame-buffer write strobe
- `wr_bank`  out  1  bank being written
- `wr_addr`  out  ADDR_W  pixel index within bank
- `wr_data`  out  16  pixel to write
- `rd_bank`  out  1  bank holding the latest complete frame
- `frame_avail`  out  1  sticky; set on the first good frame
- `frame_ready`  out  1  one-cycle pulse per good frame
- `busy`  out  1  state ≠ IDLE
- `frame_count`  out  8  good frames since reset, wraps 255→0
- `err_overflow`  out  1  sticky; pixel arrived after the frame was full
- `err_short`  out  1  sticky; frame ended with fewer than H_RES*V_RES pixels

## Operation
- FRAME_PIXELS = H_RES*V_RES. The pixel counter `pix_cnt` is ADDR_W+1 bits wide, so it cannot wrap.
- States:
  - IDLE: on `cmd_start` → ARM_HI. Latch the mode, clear both errors and `pix_cnt`.
  - ARM_HI: wait until `vsync`=1 → ARM_LO. Never start mid-frame.
  - ARM_LO: on the `vsync` falling edge (registered `vsync` = 1, current = 0) → CAPTURE with `pix_cnt`=0.
  - CAPTURE: for each `pixel_valid`:
    - if `pix_cnt` < FRAME_PIXELS: write `pix_cnt` to `wr_addr`, then increment `pix_cnt`;
    - else: drop the pixel, no write, set `err_overflow`.
    - On `frame_done` → EOF.
  - EOF (one cycle):
    - if `pix_cnt` = FRAME_PIXELS: `rd_bank` ← `wr_bank`, toggle `wr_bank`, pulse `frame_ready`, set `frame_avail`, increment `frame_count`;
    - else: set `err_short`; banks and counters unchanged (write bank is reused).
    - Clear `pix_cnt`. Then → IDLE if single mode or stop pending, else → ARM_LO (`vsync` is already high).
- `cmd_stop`:
  - in ARM_HI/ARM_LO → IDLE next cycle;
  - in CAPTURE/EOF: set `stop_pend`; the current frame completes normally, then → IDLE.
  - `stop_pend` is cleared in IDLE.
- `cmd_start` outside IDLE is ignored.
- `cmd_start` and `cmd_stop` in the same cycle in IDLE: start wins, and `stop_pend` is set, so one frame is captured.
- Simultaneous `pixel_valid` and `frame_done` in CAPTURE: the pixel is processed first and counts toward the EOF completeness check.
- `vsync` rising with no `frame_done` pulse is not treated as an end of frame; only `frame_done` ends a frame.

## Timing
- All outputs are registered.
- `wr_en`/`wr_addr`/`wr_data` appear 1 cycle after the qualifying `pixel_valid`.
- `frame_done` → EOF state next cycle. `frame_ready`, bank swap and `frame_count` update are visible 2 cycles after `frame_done`.
- The bank swap happens after the last write strobe, so a write never lands in the new bank.
- Reset (async assert, sync deassert handled upstream): state IDLE, `pix_cnt` 0, `wr_bank` 0, `rd_bank` 0, all other outputs 0.
- Reset mid-frame discards the partial frame with no error flagged.
- `wr_en` is never high in IDLE, ARM_HI, ARM_LO or EOF.

## Structure
- Package `camera_pkg`:
  - state enum (IDLE, ARM_HI, ARM_LO, CAPTURE, EOF);
  - QVGA constants (H_RES, V_RES, FRAME_PIXELS, ADDR_W);
  - RGB565 pixel typedef.
- Sub-module `vsync_edge`: registers `vsync` and outputs `vs_rise`/`vs_fall` pulses. It is reused by the display timing logic.

## Test plan
All scenarios use H_RES=4, V_RES=2 (8 pixels).
1. Single shot: `cmd_start` (`cmd_continuous`=0) while `vsync`=0 mid-frame. No writes until `vsync` goes 1 then 0. Then 8 pixels → addresses 0..7 in bank 0, and `frame_done` →:
   - `frame_ready` pulse 2 cycles later;
   - `rd_bank`=0, `wr_bank`=1, `frame_count`=1;
   - `busy` falls.
2. Continuous: 3 good frames → banks written 0, 1, 0; `rd_bank` sequence 0, 1, 0; `frame_count`=3. Then `cmd_stop` mid-frame 4 → frame 4 completes (`frame_count`=4), then IDLE.
3. Short frame: only 6 pixels before `frame_done` → `err_short`=1, no `frame_ready`, `wr_bank` unchanged. The next good frame rewrites addresses 0..7 of the same bank.
4. Overflow: 10 pixels before `frame_done` → only addresses 0..7 written, `err_overflow`=1. The frame still counts as good (`frame_count`+1). The next `cmd_start` clears `err_overflow`.
5. `pixel_valid` and `frame_done` in the same cycle on the 8th pixel → address 7 written, good frame. Separately, `cmd_stop` in ARM_LO → IDLE, no writes.
6. `reset_n` low during CAPTURE at pixel 5 → all outputs 0 immediately. After release, `cmd_start` restarts cleanly at address 0 in bank 0.

Source files
------------

// File: rtl/camera_pkg.sv
// camera_pkg
// Shared types and constants for the camera capture path.
//   cap_state_t : capture sequencer states
//   QVGA_*      : default frame geometry and frame-buffer address width
//   rgb565_t    : one assembled RGB565 pixel
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM_HI,
        ARM_LO,
        CAPTURE,
        EOF
    } cap_state_t;

    localparam int QVGA_H_RES        = 320;
    localparam int QVGA_V_RES        = 240;
    localparam int QVGA_FRAME_PIXELS = QVGA_H_RES * QVGA_V_RES;
    localparam int QVGA_ADDR_W       = 17;

    typedef struct packed {
        logic [4:0] red;
        logic [5:0] green;
        logic [4:0] blue;
    } rgb565_t;

endpackage

// File: rtl/vsync_edge.sv
// vsync_edge
// Registers the raw camera vsync and flags its edges.
//   p_clock  in  : pixel clock
//   reset_n  in  : asynchronous active-low reset
//   vsync    in  : raw vsync, high during vertical blanking
//   vs_rise  out : high for the cycle vsync is 1 after being 0
//   vs_fall  out : high for the cycle vsync is 0 after being 1
module vsync_edge (
    input  logic p_clock,
    input  logic reset_n,
    input  logic vsync,
    output logic vs_rise,
    output logic vs_fall
);

    logic vs_q;

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vsync;
        end
    end

    assign vs_rise = vsync & ~vs_q;
    assign vs_fall = ~vsync & vs_q;

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// Sequences capture of the pixel stream into a double-buffered frame store.
//   p_clock, reset_n          : clock, asynchronous active-low reset
//   vsync                     : raw vsync (high = blanking)
//   pixel_data, pixel_valid   : assembled RGB565 pixel and its qualifier
//   frame_done                : end-of-frame pulse from the assembler
//   cmd_start, cmd_stop       : arm / stop pulses from the system controller
//   cmd_continuous            : run mode, sampled with cmd_start
//   wr_en, wr_bank, wr_addr,
//   wr_data                   : frame-buffer write port
//   rd_bank                   : bank holding the newest complete frame
//   frame_avail, frame_ready  : sticky / per-frame good-frame indications
//   busy, frame_count         : status
//   err_overflow, err_short   : sticky error flags, cleared by cmd_start
module frame_capture_ctrl
    import camera_pkg::*;
#(
    parameter int H_RES  = QVGA_H_RES,
    parameter int V_RES  = QVGA_V_RES,
    parameter int ADDR_W = QVGA_ADDR_W
) (
    input  logic              p_clock,
    input  logic              reset_n,
    input  logic              vsync,
    input  rgb565_t           pixel_data,
    input  logic              pixel_valid,
    input  logic              frame_done,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_continuous,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output rgb565_t           wr_data,
    output logic              rd_bank,
    output logic              frame_avail,
    output logic              frame_ready,
    output logic              busy,
    output logic [7:0]        frame_count,
    output logic              err_overflow,
    output logic              err_short
);

    // One extra bit so the counter saturates-by-compare instead of wrapping
    // when the camera sends more pixels than a frame holds.
    localparam int                CNT_W        = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  FRAME_PIXELS = CNT_W'(H_RES * V_RES);

    cap_state_t       state;
    logic [CNT_W-1:0] pix_cnt;
    logic             cont_mode;
    logic             stop_pend;
    logic             vs_fall;
    logic             vs_rise_unused;

    // The rising edge is consumed by the display timing logic, not here.
    vsync_edge u_vsync_edge (
        .p_clock (p_clock),
        .reset_n (reset_n),
        .vsync   (vsync),
        .vs_rise (vs_rise_unused),
        .vs_fall (vs_fall)
    );

    always_ff @(posedge p_clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            cont_mode    <= 1'b0;
            stop_pend    <= 1'b0;
            wr_en        <= 1'b0;
            wr_bank      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            rd_bank      <= 1'b0;
            frame_avail  <= 1'b0;
            frame_ready  <= 1'b0;
            busy         <= 1'b0;
            frame_count  <= '0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            frame_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        state        <= ARM_HI;
                        busy         <= 1'b1;
                        cont_mode    <= cmd_continuous;
                        // A stop arriving with the start still yields one frame.
                        stop_pend    <= cmd_stop;
                        err_overflow <= 1'b0;
                        err_short    <= 1'b0;
                        pix_cnt      <= '0;
                    end else begin
                        stop_pend <= 1'b0;
                    end
                end

                // Wait for blanking so capture never begins mid-frame.
                ARM_HI: begin
                    if (cmd_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vsync) begin
                        state <= ARM_LO;
                    end
                end

                ARM_LO: begin
                    if (cmd_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_fall) begin
                        state   <= CAPTURE;
                        pix_cnt <= '0;
                    end
                end

                // A pixel sharing its cycle with frame_done is written first
                // and counts toward the completeness check in EOF.
                CAPTURE: begin
                    if (cmd_stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (pixel_valid) begin
                        if (pix_cnt < FRAME_PIXELS) begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix_cnt[ADDR_W-1:0];
                            wr_data <= pixel_data;
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end else begin
                            err_overflow <= 1'b1;
                        end
                    end
                    if (frame_done) begin
                        state <= EOF;
                    end
                end

                // Banks swap only here, one cycle after the last write strobe.
                // A short frame leaves wr_bank alone so the next frame
                // overwrites the same bank.
                EOF: begin
                    if (pix_cnt == FRAME_PIXELS) begin
                        rd_bank     <= wr_bank;
                        wr_bank     <= ~wr_bank;
                        frame_ready <= 1'b1;
                        frame_avail <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end else begin
                        err_short <= 1'b1;
                    end
                    pix_cnt <= '0;
                    if (!cont_mode || stop_pend || cmd_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // vsync is already high after frame_done, so re-arm
                        // directly on the next falling edge.
                        state <= ARM_LO;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl
// Directed bench for frame_capture_ctrl with a 4x2 frame (8 pixels).
module tb_frame_capture_ctrl;

    logic        p_clock;
    logic        reset_n = 1'b1;
    logic        vsync = 1'b0;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_done = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        cmd_continuous = 1'b0;
    logic        wr_en;
    logic        wr_bank;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_bank;
    logic        frame_avail;
    logic        frame_ready;
    logic        busy;
    logic [7:0]  frame_count;
    logic        err_overflow;
    logic        err_short;

    int n_checks = 0;
    int n_fail   = 0;

    frame_capture_ctrl #(
        .H_RES  (4),
        .V_RES  (2),
        .ADDR_W (3)
    ) dut (
        .p_clock        (p_clock),
        .reset_n        (reset_n),
        .vsync          (vsync),
        .pixel_data     (pixel_data),
        .pixel_valid    (pixel_valid),
        .frame_done     (frame_done),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_continuous (cmd_continuous),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_bank        (rd_bank),
        .frame_avail    (frame_avail),
        .frame_ready    (frame_ready),
        .busy           (busy),
        .frame_count    (frame_count),
        .err_overflow   (err_overflow),
        .err_short      (err_short)
    );

    initial p_clock = 1'b0;
    always #5 p_clock = ~p_clock;

    typedef struct {
        logic        vs;
        logic        pv;
        logic [15:0] pd;
        logic        fd;
        logic        st;
        logic        sp;
        logic        ct;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        wb;
        logic        bsy;
        logic        rdy;
        logic [7:0]  fc;
        logic        rdb;
        logic        avail;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one half cycle
    // after the rising edge that produced them.
    task automatic tick();
        @(posedge p_clock);
        @(negedge p_clock);
    endtask

    function automatic logic [15:0] pix_val(input int k);
        return 16'hA500 + 16'(k * 3);
    endfunction

    task automatic do_reset(input string tag);
        @(negedge p_clock);
        reset_n = 1'b0;
        #1;
        check({tag, ".wr_en"},   wr_en, 0);
        check({tag, ".wr_bank"}, wr_bank, 0);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".wr_data"}, wr_data, 0);
        check({tag, ".rd_bank"}, rd_bank, 0);
        check({tag, ".avail"},   frame_avail, 0);
        check({tag, ".ready"},   frame_ready, 0);
        check({tag, ".busy"},    busy, 0);
        check({tag, ".fcount"},  frame_count, 0);
        check({tag, ".ovf"},     err_overflow, 0);
        check({tag, ".short"},   err_short, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_cmd(input string tag, input logic cont, input logic stop);
        cmd_start      = 1'b1;
        cmd_continuous = cont;
        cmd_stop       = stop;
        tick();
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        check({tag, ".start.busy"},  busy, 1);
        check({tag, ".start.ovf"},   err_overflow, 0);
        check({tag, ".start.short"}, err_short, 0);
    endtask

    task automatic pixel(input string tag, input int k, input bit fd, input bit stop,
                         input bit exp_we, input logic exp_bank);
        pixel_valid = 1'b1;
        pixel_data  = pix_val(k);
        frame_done  = fd;
        cmd_stop    = stop;
        tick();
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        cmd_stop    = 1'b0;
        check($sformatf("%s.p%0d.we", tag, k), wr_en, exp_we);
        if (exp_we) begin
            check($sformatf("%s.p%0d.addr", tag, k), wr_addr, k);
            check($sformatf("%s.p%0d.bank", tag, k), wr_bank, exp_bank);
            check($sformatf("%s.p%0d.data", tag, k), wr_data, pix_val(k));
        end
    endtask

    task automatic enter_capture(input string tag);
        vsync = 1'b1;
        tick();
        check({tag, ".vs_hi.we"}, wr_en, 0);
        tick();
        vsync = 1'b0;
        tick();
        check({tag, ".vs_fall.busy"}, busy, 1);
    endtask

    // Leaves the DUT in EOF with pre-EOF outputs visible.
    task automatic send_frame(input string tag, input int n_pix, input bit fd_last,
                              input logic bank, input int stop_at);
        enter_capture(tag);
        for (int k = 0; k < n_pix; k++) begin
            pixel(tag, k, fd_last && (k == n_pix - 1), k == stop_at, k < 8, bank);
        end
        if (!fd_last) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            check({tag, ".eof.we"}, wr_en, 0);
        end
        check({tag, ".eof.ready"}, frame_ready, 0);
    endtask

    task automatic eof_status(input string tag, input logic rdy, input logic wb, input logic rdb,
                              input logic [7:0] fc, input logic avail, input logic bsy,
                              input logic ovf, input logic shrt);
        tick();
        check({tag, ".ready"},   frame_ready, rdy);
        check({tag, ".wr_bank"}, wr_bank, wb);
        check({tag, ".rd_bank"}, rd_bank, rdb);
        check({tag, ".fcount"},  frame_count, fc);
        check({tag, ".avail"},   frame_avail, avail);
        check({tag, ".busy"},    busy, bsy);
        check({tag, ".ovf"},     err_overflow, ovf);
        check({tag, ".short"},   err_short, shrt);
        check({tag, ".we"},      wr_en, 0);
    endtask

    initial begin
        // Single shot: vs, pv, pd, fd, start, stop, cont | we, wa, wd, wb, busy, rdy, fc, rdb, avail
        tbl[0]  = '{0, 0, 16'h0000, 0, 1, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 16'hAAAA, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 16'hBBBB, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            tbl[(k < 4) ? 5 + k : 6 + k] =
                '{0, 1, pix_val(k), 0, 0, 0, 0,  1, 3'(k), pix_val(k), 0, 1, 0, 0, 0, 0};
        end
        tbl[9]  = '{0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 16'h0000, 1, 0, 0, 0,  0, 0, 16'h0000, 0, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 0, 1, 1, 0, 1};
        tbl[16] = '{0, 0, 16'h0000, 0, 0, 0, 0,  0, 0, 16'h0000, 1, 0, 0, 1, 0, 1};

        do_reset("rst0");

        for (int i = 0; i < 17; i++) begin
            vsync          = tbl[i].vs;
            pixel_valid    = tbl[i].pv;
            pixel_data     = tbl[i].pd;
            frame_done     = tbl[i].fd;
            cmd_start      = tbl[i].st;
            cmd_stop       = tbl[i].sp;
            cmd_continuous = tbl[i].ct;
            tick();
            check($sformatf("t%0d.we", i), wr_en, tbl[i].we);
            if (tbl[i].we) begin
                check($sformatf("t%0d.addr", i), wr_addr, tbl[i].wa);
                check($sformatf("t%0d.data", i), wr_data, tbl[i].wd);
            end
            check($sformatf("t%0d.wr_bank", i), wr_bank, tbl[i].wb);
            check($sformatf("t%0d.busy", i),    busy, tbl[i].bsy);
            check($sformatf("t%0d.ready", i),   frame_ready, tbl[i].rdy);
            check($sformatf("t%0d.fcount", i),  frame_count, tbl[i].fc);
            check($sformatf("t%0d.rd_bank", i), rd_bank, tbl[i].rdb);
            check($sformatf("t%0d.avail", i),   frame_avail, tbl[i].avail);
        end
        pixel_valid = 1'b0;
        frame_done  = 1'b0;
        cmd_start   = 1'b0;
        cmd_stop    = 1'b0;

        // Continuous: three frames, then stop during the fourth.
        do_reset("rst1");
        start_cmd("cont", 1'b1, 1'b0);
        send_frame("c1", 8, 1'b0, 1'b0, -1);
        eof_status("c1", 1, 1, 0, 8'd1, 1, 1, 0, 0);
        send_frame("c2", 8, 1'b0, 1'b1, -1);
        eof_status("c2", 1, 0, 1, 8'd2, 1, 1, 0, 0);
        send_frame("c3", 8, 1'b0, 1'b0, -1);
        eof_status("c3", 1, 1, 0, 8'd3, 1, 1, 0, 0);
        send_frame("c4", 8, 1'b0, 1'b1, 3);
        eof_status("c4", 1, 0, 1, 8'd4, 1, 0, 0, 0);
        tick();
        check("c4.after.ready", frame_ready, 0);
        check("c4.after.busy", busy, 0);

        // Short frame, then a good frame into the same bank.
        do_reset("rst2");
        start_cmd("short", 1'b1, 1'b0);
        send_frame("s1", 6, 1'b0, 1'b0, -1);
        eof_status("s1", 0, 0, 0, 8'd0, 0, 1, 0, 1);
        send_frame("s2", 8, 1'b0, 1'b0, 2);
        eof_status("s2", 1, 1, 0, 8'd1, 1, 0, 0, 1);

        // Overflow: extra pixels dropped, frame still good.
        start_cmd("ovf", 1'b0, 1'b0);
        send_frame("o1", 10, 1'b0, 1'b1, -1);
        eof_status("o1", 1, 0, 1, 8'd2, 1, 0, 1, 0);
        start_cmd("ovf_clr", 1'b0, 1'b0);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("arm_hi.stop.busy", busy, 0);

        // Last pixel coincides with frame_done.
        start_cmd("same", 1'b0, 1'b0);
        send_frame("sc", 8, 1'b1, 1'b0, -1);
        eof_status("sc", 1, 1, 0, 8'd3, 1, 0, 0, 0);

        // Stop while waiting for the vsync falling edge.
        start_cmd("armlo", 1'b1, 1'b0);
        vsync = 1'b1;
        tick();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("arm_lo.stop.busy", busy, 0);
        vsync       = 1'b0;
        pixel_valid = 1'b1;
        tick();
        check("arm_lo.stop.we0", wr_en, 0);
        tick();
        check("arm_lo.stop.we1", wr_en, 0);
        check("arm_lo.stop.busy1", busy, 0);
        pixel_valid = 1'b0;

        // Start and stop together: exactly one frame in continuous mode.
        start_cmd("ss", 1'b1, 1'b1);
        send_frame("ss", 8, 1'b0, 1'b1, -1);
        eof_status("ss", 1, 0, 1, 8'd4, 1, 0, 0, 0);

        // Reset in the middle of a capture.
        start_cmd("mid", 1'b0, 1'b0);
        enter_capture("mid");
        for (int k = 0; k < 5; k++) begin
            pixel("mid", k, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        do_reset("rst3");
        start_cmd("post", 1'b0, 1'b0);
        send_frame("post", 8, 1'b0, 1'b0, -1);
        eof_status("post", 1, 1, 0, 8'd1, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
